// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall-bus, exception-code and FSM definitions for pipe_ctrl.
package pipe_ctrl_pkg;
  localparam int STG_PC = 0;
  localparam int STG_IF = 1;
  localparam int STG_IF2 = 2;
  localparam int STG_ID = 3;
  localparam int STG_EX = 4;
  localparam int STG_PREMEM = 5;
  localparam int STALL_W = STG_PREMEM + 1;
  typedef logic [STALL_W-1:0] stall_t;
  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_IF = 6'b000111;
  localparam stall_t STALL_ID = 6'b001111;
  localparam stall_t STALL_EX = 6'b011111;
  localparam stall_t STALL_MEM = 6'b111111;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
  localparam logic [31:0] EXC_INT = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_BREAK = 32'h9;
  localparam logic [31:0] EXC_RI = 32'hA;
  localparam logic [31:0] EXC_OV = 32'hC;
  localparam logic [31:0] EXC_TRAP = 32'hD;
  localparam logic [31:0] EXC_ERET = 32'hE;
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  function automatic logic [31:0] exc_target(input logic [31:0] excepttype, input logic [31:0] epc);
    return excepttype == EXC_ERET ? epc : EXC_VECTOR;
  endfunction
endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// pipe_perf_cnt: saturating up-counter with enable.
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (en && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall-bus merge plus exception/ERET freeze-drain-flush sequencing;
// PIPE_PERF_CNT_EN compiles in the stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         stallreq_if,
  input  logic         stallreq_id,
  input  logic         stallreq_ex,
  input  logic         stallreq_mem,
  input  logic         if_busy,
  input  logic [31:0]  excepttype,
  input  logic [31:0]  cp0_epc,
  output logic [5:0]   stall,
  output logic         flush,
  output logic [31:0]  new_pc,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  flush_count
);
  logic [1:0] state, state_nx;
  logic [31:0] target, target_nx;
  logic exc;
  stall_t run_stall;
  assign exc = state == ST_RUN && excepttype != 32'h0;
  always_comb begin
    run_stall = stallreq_mem ? STALL_MEM : stallreq_ex ? STALL_EX : stallreq_id ? STALL_ID :
                stallreq_if ? STALL_IF : STALL_NONE;
    stall = (rst || state == ST_FLUSH) ? STALL_NONE : (state == ST_DRAIN || exc) ? STALL_MEM : run_stall;
    state_nx = state == ST_FLUSH ? ST_RUN : (state == ST_DRAIN || exc) ? (if_busy ? ST_DRAIN : ST_FLUSH) : ST_RUN;
    target_nx = exc ? exc_target(excepttype, cp0_epc) : target;
  end
  // flush/new_pc are registered so they line up with the FLUSH state itself
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_RUN;
      target <= '0;
      flush <= 1'b0;
      new_pc <= '0;
    end else begin
      state <= state_nx;
      target <= target_nx;
      flush <= state_nx == ST_FLUSH;
      new_pc <= state_nx == ST_FLUSH ? target_nx : 32'h0;
    end
`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt #(.W(32)) u_stall_cnt (.clk(clk), .rst(rst), .en(stall != STALL_NONE), .count(stall_cycles));
  pipe_perf_cnt #(.W(32)) u_flush_cnt (.clk(clk), .rst(rst), .en(flush), .count(flush_count));
`else
  assign stall_cycles = 32'h0;
  assign flush_count = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus, per-cycle model comparison and literal checkpoints for pipe_ctrl.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0, if_busy = 1'b0;
  logic [31:0] excepttype = 32'h0, cp0_epc = 32'h0;
  logic [5:0] stall;
  logic flush;
  logic [31:0] new_pc, stall_cycles, flush_count;
  int n_chk = 0;
  int n_fail = 0;
  bit frozen = 1'b0;
  bit flush_due = 1'b0;
  logic [31:0] tgt = 32'h0, sc = 32'h0, fc = 32'h0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem), .if_busy(if_busy),
    .excepttype(excepttype), .cp0_epc(cp0_epc), .stall(stall), .flush(flush),
    .new_pc(new_pc), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // stall depth counts how many leading stages freeze: mem 6, ex 5, id 4, if 3
  function automatic logic [5:0] exp_stall();
    int lvl;
    if (rst || flush_due) return 6'd0;
    if (frozen || excepttype != 0) return 6'h3F;
    lvl = stallreq_mem ? 6 : stallreq_ex ? 5 : stallreq_id ? 4 : stallreq_if ? 3 : 0;
    return 6'((1 << lvl) - 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      frozen = 0; flush_due = 0; tgt = 0; sc = 0; fc = 0;
    end else begin
      if (exp_stall() != 0 && sc != 32'hFFFFFFFF) sc = sc + 1;
      if (flush_due && fc != 32'hFFFFFFFF) fc = fc + 1;
      if (flush_due) flush_due = 0;
      else if (frozen) begin
        if (!if_busy) begin frozen = 0; flush_due = 1; end
      end else if (excepttype != 0) begin
        tgt = excepttype == 32'hE ? cp0_epc : 32'hBFC00380;
        if (if_busy) frozen = 1; else flush_due = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_stall", {26'h0, stall}, {26'h0, exp_stall()});
    chk("model_flush", {31'h0, flush}, {31'h0, !rst && flush_due});
    chk("model_new_pc", new_pc, (!rst && flush_due) ? tgt : 32'h0);
`ifdef PIPE_PERF_CNT_EN
    chk("model_stall_cycles", stall_cycles, rst ? 32'h0 : sc);
    chk("model_flush_count", flush_count, rst ? 32'h0 : fc);
`else
    chk("model_stall_cycles", stall_cycles, 32'h0);
    chk("model_flush_count", flush_count, 32'h0);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    stallreq_if = 1; stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1; if_busy = 1;
    at_neg();
    chk("reset_stall", {26'h0, stall}, 32'h0);
    chk("reset_flush", {31'h0, flush}, 32'h0);
    chk("reset_new_pc", new_pc, 32'h0);
    cyc();
    cyc(); rst = 0; if_busy = 0;
    at_neg(); chk("post_reset_stall", {26'h0, stall}, 32'h3F);
    chk("post_reset_flush", {31'h0, flush}, 32'h0);
    cyc(); stallreq_id = 0; stallreq_mem = 0;
    at_neg(); chk("prio_if_ex", {26'h0, stall}, 32'h1F);
    cyc(); stallreq_mem = 1;
    at_neg(); chk("prio_mem", {26'h0, stall}, 32'h3F);
    cyc(); stallreq_if = 0; stallreq_ex = 0; stallreq_mem = 0;
    at_neg(); chk("prio_none", {26'h0, stall}, 32'h0);
    cyc(); stallreq_id = 1;
    at_neg(); chk("prio_id", {26'h0, stall}, 32'h0F);
    cyc(); stallreq_id = 0; stallreq_if = 1;
    at_neg(); chk("prio_if", {26'h0, stall}, 32'h07);
    cyc(); stallreq_if = 0; excepttype = 32'hC;
    at_neg(); chk("exc_freeze", {26'h0, stall}, 32'h3F);
    chk("exc_no_flush_yet", {31'h0, flush}, 32'h0);
    cyc(); excepttype = 0;
    at_neg(); chk("exc_flush", {31'h0, flush}, 32'h1);
    chk("exc_new_pc", new_pc, 32'hBFC00380);
    chk("exc_flush_stall", {26'h0, stall}, 32'h0);
    cyc();
    at_neg(); chk("exc_flush_done", {31'h0, flush}, 32'h0);
    chk("exc_new_pc_zero", new_pc, 32'h0);
    cyc(); cp0_epc = 32'h80001234; excepttype = 32'hE; if_busy = 1;
    at_neg(); chk("eret_stall0", {26'h0, stall}, 32'h3F);
    cyc(); excepttype = 0; cp0_epc = 32'h11111111;
    at_neg(); chk("eret_stall1", {26'h0, stall}, 32'h3F);
    cyc();
    at_neg(); chk("eret_stall2", {26'h0, stall}, 32'h3F);
    cyc(); if_busy = 0;
    at_neg(); chk("eret_stall3", {26'h0, stall}, 32'h3F);
    chk("eret_no_flush_yet", {31'h0, flush}, 32'h0);
    cyc();
    at_neg(); chk("eret_flush", {31'h0, flush}, 32'h1);
    chk("eret_new_pc", new_pc, 32'h80001234);
    cyc(); stallreq_mem = 1; excepttype = 32'h8;
    at_neg(); chk("mem_exc_stall", {26'h0, stall}, 32'h3F);
    cyc(); excepttype = 0;
    at_neg(); chk("mem_exc_flush", {31'h0, flush}, 32'h1);
    chk("mem_exc_stall_flush", {26'h0, stall}, 32'h0);
    chk("mem_exc_new_pc", new_pc, 32'hBFC00380);
    cyc(); stallreq_mem = 0;
    cyc(); excepttype = 32'hE; cp0_epc = 32'h80001234; if_busy = 1;
    cyc(); excepttype = 32'h4;
    at_neg(); chk("second_exc_stall", {26'h0, stall}, 32'h3F);
    chk("second_exc_no_flush", {31'h0, flush}, 32'h0);
    cyc(); excepttype = 0; if_busy = 0;
    cyc();
    at_neg(); chk("second_exc_flush", {31'h0, flush}, 32'h1);
    chk("second_exc_keeps_first", new_pc, 32'h80001234);
    cyc(); excepttype = 32'hC; if_busy = 1;
    cyc(); excepttype = 0; rst = 1;
    at_neg(); chk("rst_drain_stall", {26'h0, stall}, 32'h0);
    cyc(); rst = 0; if_busy = 0;
    at_neg(); chk("rst_drain_stall_after", {26'h0, stall}, 32'h0);
    cyc();
    at_neg(); chk("rst_drain_lost", {31'h0, flush}, 32'h0);
    cyc(); stallreq_if = 1;
    cyc();
    cyc();
    cyc(); stallreq_if = 0; excepttype = 32'h1;
    cyc(); excepttype = 0;
    cyc(); excepttype = 32'h9;
    cyc(); excepttype = 0;
    cyc();
    at_neg();
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall_cycles", stall_cycles, 32'd5);
    chk("perf_flush_count", flush_count, 32'd2);
    cyc();
    force dut.u_stall_cnt.count = 32'hFFFFFFFE;
    sc = 32'hFFFFFFFE;
    stallreq_ex = 1;
    #1 release dut.u_stall_cnt.count;
    cyc();
    cyc();
    at_neg(); chk("perf_saturate", stall_cycles, 32'hFFFFFFFF);
    stallreq_ex = 0;
`else
    chk("perf_off_stall_cycles", stall_cycles, 32'h0);
    chk("perf_off_flush_count", flush_count, 32'h0);
`endif
    cyc();
    at_neg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
